mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline, between the EX/MEM pipeline register and the write-back selector. Issues loads/stores on the data bus through a two-state handshake FSM, stalls the pipeline until the bus acknowledges, aligns and extends load data, and holds the MEM/WB pipeline register (`W_*` outputs) that write-back consumes. Misaligned accesses are trapped here without any bus access.

## Interface
Parameters
- None. Widths are fixed: 32-bit data/address, 5-bit register index.

Ports
- Clock and reset: one clock; reset is synchronous and active-low. Clock is `clk`, reset is `resetn`.
- `clk` in 1: clock, all state on rising edge.
- `resetn` in 1: synchronous active-low reset.
- `M_valid` in 1: instruction present in MEM.
- `M_alu_res` in 32: ALU result; the byte address for memory ops.
- `M_wdata` in 32: store data, right-aligned.
- `M_mem_re` / `M_mem_we` in 1 each: load / store; never both set.
- `M_mem_size` in 2: 0 byte, 1 half, 2 word; 3 is treated as word.
- `M_mem_unsigned` in 1: zero-extend load, else sign-extend.
- `M_regsrc_sel` in 1: forwarded to `W_regsrc_sel`.
- `M_reg_dst` in 5, `M_reg_we` in 1: destination register and its write enable.
- `M_stall` out 1: hold EX/MEM and upstream stages.
- `dmem_req` out 1, `dmem_wr` out 1, `dmem_addr` out 32 (word-aligned), `dmem_wdata` out 32, `dmem_wstrb` out 4: bus request.
- `dmem_ack` in 1, `dmem_rdata` in 32: completion; rdata valid with ack for reads.
- `W_valid`, `W_alu_res`[32], `W_mem_data`[32], `W_regsrc_sel`, `W_reg_dst`[5], `W_reg_we`, `W_exc` out: MEM/WB register.

## Operation
- FSM states: IDLE, REQ.
- IDLE, no memory op, or `M_valid`=0:
  - Next edge loads the W register from the M inputs.
  - `W_valid`=`M_valid`.
  - `W_mem_data`=0.
  - `M_stall`=0.
- IDLE, misaligned op:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]≠0.
  - No bus access and no stall.
  - Next edge sets `W_exc`=1, `W_reg_we`=0, `W_valid`=1.
- IDLE, aligned memory op:
  - `M_stall`=1.
  - Latch the request registers, go to REQ.
  - Next edge sets `W_valid`=0, which makes it a bubble.
- REQ:
  - `dmem_req`=1. Address, wdata, strb and wr stay stable until ack.
  - While `dmem_ack`=0: `M_stall`=1, W holds a bubble.
  - When `dmem_ack`=1: `M_stall`=0 combinationally.
  - On that edge W loads the M inputs (still held), `W_mem_data` gets the extracted load data (0 for stores), and the FSM returns to IDLE.
- Store strobe, with off=addr[1:0]:
  - byte: 4'b0001<<off; half: 4'b0011<<off; word: 4'b1111.
  - `dmem_wdata`: byte replicated ×4, half replicated ×2, word as is.
- Load extract: take rdata byte at off, or half at off[1]. Extend to 32 bits per `M_mem_unsigned`. Word passes unchanged.
- `dmem_addr` = {addr[31:2], 2'b00}.

## Timing
- Reset values:
  - state IDLE.
  - `dmem_req`=0, `dmem_wr`=0, `dmem_addr`=0, `dmem_wdata`=0, `dmem_wstrb`=0.
  - All `W_*`=0.
  - `M_stall`=0.
- Reset asserted while in REQ abandons the access: `dmem_req`=0 the following cycle, and no W update.
- Latency:
  - Non-memory op: 1 edge to W.
  - Memory op with zero-wait ack: 2 edges.
  - Each additional cycle without ack adds 1 edge.
- `dmem_ack` while not in REQ is ignored.
- Back-to-back memory ops: the second enters IDLE on the cycle after ack, so at most one access is in flight.
- Ack in the same cycle as REQ entry is impossible, because the request is registered.

## Structure
- Shared package `mem_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), state enum, misalignment function.
- Sub-module `mem_load_align`: combinational rdata extractor/extender (inputs rdata, off, size, unsigned).
- Strobe/replicate logic and the FSM stay in `mem_stage`.

## Test plan
- Non-memory op, `M_alu_res`=0x1234: one edge later, `W_alu_res`=0x1234, `W_valid`=1, `dmem_req` never asserted.
- `lb`, addr 0x103, rdata 0x80FF_FF7F, ack after 3 wait cycles:
  - `dmem_addr`=0x100.
  - `M_stall` high 4 cycles.
  - `W_mem_data`=0xFFFF_FF80.
- `lhu` addr 0x22, rdata 0xBEEF_0000, zero-wait: `W_mem_data`=0x0000_BEEF, 2 edges total.
- `sb` addr 0x41, wdata 0xAB: `dmem_wstrb`=4'b0010, `dmem_wdata`=0xABAB_ABAB, `dmem_wr`=1.
- `lw` at 0x6: no `dmem_req`, `W_exc`=1, `W_reg_we`=0, no stall.
- `resetn` low in REQ before ack: next cycle `dmem_req`=0, `W_valid`=0, state IDLE.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: access size codes, FSM states
// and the alignment rule used to trap bad accesses before they reach the bus.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Size code 3 is treated like a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (size == SZ_HALF) begin
            bad = off[0];
        end else if (size != SZ_BYTE) begin
            bad = (off != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_lane[gi] = rdata[8*gi +: 8];
    end

    assign byte_sel = byte_lane[off];
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        case (size)
            SZ_BYTE: data = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{~load_unsigned & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: registered bus handshake, stall generation, store lane
// steering, load alignment and the MEM/WB register consumed by write-back.
module mem_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        M_valid,
    input  logic [31:0] M_alu_res,
    input  logic [31:0] M_wdata,
    input  logic        M_mem_re,
    input  logic        M_mem_we,
    input  logic [1:0]  M_mem_size,
    input  logic        M_mem_unsigned,
    input  logic        M_regsrc_sel,
    input  logic [4:0]  M_reg_dst,
    input  logic        M_reg_we,
    output logic        M_stall,
    output logic        dmem_req,
    output logic        dmem_wr,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        W_valid,
    output logic [31:0] W_alu_res,
    output logic [31:0] W_mem_data,
    output logic        W_regsrc_sel,
    output logic [4:0]  W_reg_dst,
    output logic        W_reg_we,
    output logic        W_exc
);

    state_t      state_reg;
    logic [1:0]  off;
    logic        mem_op;
    logic        misaligned;
    logic        access;
    logic [3:0]  wstrb_next;
    logic [7:0]  wlane [4];
    logic [31:0] wdata_next;
    logic [31:0] load_data;

    assign off        = M_alu_res[1:0];
    assign mem_op     = M_valid & (M_mem_re | M_mem_we);
    assign misaligned = is_misaligned(M_mem_size, off);
    assign access     = mem_op & ~misaligned;

    // Ack releases the stall in the same cycle so the next op can enter IDLE right after.
    assign M_stall = resetn & ((state_reg == ST_IDLE) ? access : ~dmem_ack);

    always_comb begin
        case (M_mem_size)
            SZ_BYTE: wstrb_next = 4'b0001 << off;
            SZ_HALF: wstrb_next = 4'b0011 << off;
            default: wstrb_next = 4'b1111;
        endcase
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
        assign wlane[gi] = (M_mem_size == SZ_BYTE) ? M_wdata[7:0] :
                           (M_mem_size == SZ_HALF) ? M_wdata[8*(gi%2) +: 8] :
                                                     M_wdata[8*gi +: 8];
    end
    assign wdata_next = {wlane[3], wlane[2], wlane[1], wlane[0]};

    mem_load_align u_align (
        .rdata         (dmem_rdata),
        .off           (off),
        .size          (M_mem_size),
        .load_unsigned (M_mem_unsigned),
        .data          (load_data)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            dmem_req     <= 1'b0;
            dmem_wr      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_wstrb   <= '0;
            W_valid      <= 1'b0;
            W_alu_res    <= '0;
            W_mem_data   <= '0;
            W_regsrc_sel <= 1'b0;
            W_reg_dst    <= '0;
            W_reg_we     <= 1'b0;
            W_exc        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (access) begin
                        state_reg  <= ST_REQ;
                        dmem_req   <= 1'b1;
                        dmem_wr    <= M_mem_we;
                        dmem_addr  <= {M_alu_res[31:2], 2'b00};
                        dmem_wdata <= M_mem_we ? wdata_next : 32'h0;
                        dmem_wstrb <= M_mem_we ? wstrb_next : 4'b0000;
                        W_valid    <= 1'b0;
                        W_reg_we   <= 1'b0;
                        W_exc      <= 1'b0;
                    end else begin
                        W_valid      <= M_valid;
                        W_alu_res    <= M_alu_res;
                        W_mem_data   <= 32'h0;
                        W_regsrc_sel <= M_regsrc_sel;
                        W_reg_dst    <= M_reg_dst;
                        W_reg_we     <= M_reg_we & ~(mem_op & misaligned);
                        W_exc        <= mem_op & misaligned;
                    end
                end
                ST_REQ: begin
                    if (dmem_ack) begin
                        state_reg    <= ST_IDLE;
                        dmem_req     <= 1'b0;
                        W_valid      <= M_valid;
                        W_alu_res    <= M_alu_res;
                        W_mem_data   <= M_mem_re ? load_data : 32'h0;
                        W_regsrc_sel <= M_regsrc_sel;
                        W_reg_dst    <= M_reg_dst;
                        W_reg_we     <= M_reg_we;
                        W_exc        <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage against an arithmetic reference model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        M_valid, M_mem_re, M_mem_we, M_mem_unsigned, M_regsrc_sel, M_reg_we;
    logic [31:0] M_alu_res, M_wdata;
    logic [1:0]  M_mem_size;
    logic [4:0]  M_reg_dst;
    logic        M_stall, dmem_req, dmem_wr, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        W_valid, W_regsrc_sel, W_reg_we, W_exc;
    logic [31:0] W_alu_res, W_mem_data;
    logic [4:0]  W_reg_dst;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .resetn(resetn), .M_valid(M_valid), .M_alu_res(M_alu_res),
        .M_wdata(M_wdata), .M_mem_re(M_mem_re), .M_mem_we(M_mem_we),
        .M_mem_size(M_mem_size), .M_mem_unsigned(M_mem_unsigned),
        .M_regsrc_sel(M_regsrc_sel), .M_reg_dst(M_reg_dst), .M_reg_we(M_reg_we),
        .M_stall(M_stall), .dmem_req(dmem_req), .dmem_wr(dmem_wr),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .W_valid(W_valid),
        .W_alu_res(W_alu_res), .W_mem_data(W_mem_data), .W_regsrc_sel(W_regsrc_sel),
        .W_reg_dst(W_reg_dst), .W_reg_we(W_reg_we), .W_exc(W_exc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model written from the access rules, not from the RTL structure.
    function automatic bit model_misaligned(int size, logic [31:0] addr);
        if (size == 1) return (addr % 2) != 0;
        if (size >= 2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(int size, bit uns, logic [31:0] addr, logic [31:0] rdata);
        int unsigned off;
        logic [31:0] v;
        off = addr % 4;
        if (size == 0) begin
            v = (rdata >> (8 * off)) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = (rdata >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_strb(int size, logic [31:0] addr);
        if (size == 0) return 32'd1 << (addr % 4);
        if (size == 1) return 32'd3 << (addr % 4);
        return 32'd15;
    endfunction

    function automatic logic [31:0] model_wdata(int size, logic [31:0] wd);
        if (size == 0) return (wd & 32'hFF) * 32'h0101_0101;
        if (size == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic drive(input bit v, input bit re, input bit we, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wd,
                         input bit rsel, input logic [4:0] dst, input bit rwe);
        M_valid = v; M_mem_re = re; M_mem_we = we; M_mem_size = size;
        M_mem_unsigned = uns; M_alu_res = addr; M_wdata = wd;
        M_regsrc_sel = rsel; M_reg_dst = dst; M_reg_we = rwe;
    endtask

    task automatic do_nonmem(input logic [31:0] alu, input bit v, input logic [4:0] dst);
        drive(v, 0, 0, 2'd2, 0, alu, $urandom, 1'b1, dst, 1'b1);
        dmem_ack = 1'b1;
        dmem_rdata = $urandom;
        #1;
        chk("nonmem_stall", M_stall, 0);
        tick();
        dmem_ack = 1'b0;
        chk("nonmem_valid", W_valid, v);
        chk("nonmem_alu", W_alu_res, alu);
        chk("nonmem_data", W_mem_data, 0);
        chk("nonmem_dst", W_reg_dst, dst);
        chk("nonmem_rsel", W_regsrc_sel, 1);
        chk("nonmem_exc", W_exc, 0);
        chk("nonmem_req", dmem_req, 0);
    endtask

    task automatic do_mem(input bit re, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int waits, input logic [4:0] dst);
        int stall_cnt;
        stall_cnt = 0;
        drive(1, re, we, size, uns, addr, wd, 1'b0, dst, re);
        #1;
        if (model_misaligned(size, addr)) begin
            chk("mis_stall", M_stall, 0);
            tick();
            chk("mis_req", dmem_req, 0);
            chk("mis_exc", W_exc, 1);
            chk("mis_regwe", W_reg_we, 0);
            chk("mis_valid", W_valid, 1);
            chk("mis_data", W_mem_data, 0);
            chk("mis_alu", W_alu_res, addr);
            $display("txn mis    re=%0d we=%0d size=%0d addr=%08h exc=%0d", re, we, size, addr, W_exc);
            return;
        end
        chk("idle_stall", M_stall, 1);
        if (M_stall) stall_cnt++;
        tick();
        chk("req_req", dmem_req, 1);
        chk("req_wr", dmem_wr, we);
        chk("req_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        if (we) begin
            chk("req_strb", dmem_wstrb, model_strb(size, addr));
            chk("req_wdata", dmem_wdata, model_wdata(size, wd));
        end
        for (int w = 0; w < waits; w++) begin
            dmem_rdata = $urandom;
            #1;
            if (M_stall) stall_cnt++;
            chk("wait_bubble", W_valid, 0);
            chk("wait_req", dmem_req, 1);
            chk("wait_addr", dmem_addr, addr & 32'hFFFF_FFFC);
            tick();
        end
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        #1;
        chk("ack_stall", M_stall, 0);
        tick();
        dmem_ack = 1'b0;
        chk("stall_cycles", stall_cnt, waits + 1);
        chk("done_valid", W_valid, 1);
        chk("done_data", W_mem_data, re ? model_load(size, uns, addr, rdata) : 32'h0);
        chk("done_alu", W_alu_res, addr);
        chk("done_dst", W_reg_dst, dst);
        chk("done_regwe", W_reg_we, re);
        chk("done_exc", W_exc, 0);
        chk("done_req", dmem_req, 0);
        $display("txn mem    re=%0d we=%0d size=%0d addr=%08h waits=%0d data=%08h",
                 re, we, size, addr, waits, W_mem_data);
    endtask

    initial begin
        resetn = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        drive(1, 1, 0, 2'd2, 0, 32'h100, 32'h0, 0, 5'd1, 1);
        tick();
        tick();
        #1;
        chk("rst_stall", M_stall, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_wr", dmem_wr, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_strb", dmem_wstrb, 0);
        chk("rst_wvalid", W_valid, 0);
        chk("rst_walu", W_alu_res, 0);
        chk("rst_wdat", W_mem_data, 0);
        chk("rst_wexc", W_exc, 0);
        $display("txn reset  W_valid=%0d dmem_req=%0d", W_valid, dmem_req);
        drive(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 5'd0, 0);
        resetn = 1'b1;
        tick();

        do_nonmem(32'h1234, 1'b1, 5'd3);
        $display("txn nonmem alu=%08h valid=%0d", W_alu_res, W_valid);

        do_mem(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF_FF7F, 3, 5'd4);
        chk("lb_plan", W_mem_data, 32'hFFFF_FF80);

        do_mem(1, 0, 2'd1, 1, 32'h22, 32'h0, 32'hBEEF_0000, 0, 5'd5);
        chk("lhu_plan", W_mem_data, 32'h0000_BEEF);

        do_mem(0, 1, 2'd0, 0, 32'h41, 32'hAB, 32'h1234_5678, 1, 5'd0);
        do_mem(1, 0, 2'd2, 0, 32'h6, 32'h0, 32'h0, 0, 5'd6);

        // Abandon an access in flight by resetting during REQ.
        drive(1, 1, 0, 2'd2, 0, 32'h200, 32'h0, 0, 5'd7, 1);
        tick();
        chk("abort_inreq", dmem_req, 1);
        tick();
        resetn = 1'b0;
        tick();
        chk("abort_req", dmem_req, 0);
        chk("abort_wvalid", W_valid, 0);
        chk("abort_walu", W_alu_res, 0);
        resetn = 1'b1;
        drive(0, 0, 0, 2'd0, 0, 32'h0, 32'h0, 0, 5'd0, 0);
        #1;
        chk("abort_idle", M_stall, 0);
        $display("txn abort  dmem_req=%0d W_valid=%0d", dmem_req, W_valid);
        tick();

        for (int i = 0; i < 60; i++) begin
            int kind;
            logic [31:0] addr;
            kind = int'($urandom_range(0, 4));
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr = addr & 32'hFFFF_FFFC;
            if (kind == 0) begin
                do_nonmem(addr, 1'($urandom_range(0, 1)), 5'($urandom));
                $display("txn nonmem alu=%08h valid=%0d", W_alu_res, W_valid);
            end else if (kind <= 2) begin
                do_mem(1, 0, 2'($urandom), 1'($urandom), addr, 32'h0, $urandom,
                       int'($urandom_range(0, 3)), 5'($urandom));
            end else begin
                do_mem(0, 1, 2'($urandom), 1'($urandom), addr, $urandom, $urandom,
                       int'($urandom_range(0, 3)), 5'($urandom));
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
